// File: rtl/bg_pattern_gen.sv
// bg_pattern_gen
// ----------------------------------------------------------------------------
// Background pattern generator for the HDMI output path. Converts the
// active-area pixel coordinate from the timing generator into a 16-bit
// background pixel {4'h0, R[3:0], G[3:0], B[3:0]}. It offers four patterns:
// checkerboard, colour bars, horizontal grey gradient and solid colour.
// The pattern can only change at a frame boundary. The pipeline is two
// register stages deep and accepts one pixel per clock.
//
// Optional feature macro: BG_SCROLL_EN
//   When defined, the checkerboard scrolls horizontally by SCROLL_STEP pixels
//   on every frame_start. When undefined, the tiles are static.
//
// Ports
//   clk_i          pixel clock
//   rst_ni         asynchronous active-low reset
//   h_count_i      x coordinate (CW bits)
//   v_count_i      y coordinate (CW bits)
//   pix_valid_i    coordinate valid this cycle
//   frame_start_i  one-cycle pulse coincident with pixel (0,0)
//   mode_i         requested pattern: 0 checker, 1 bars, 2 gradient, 3 solid
//   color_a_i      checker colour A / solid colour
//   color_b_i      checker colour B
//   bg_data_o      background pixel, two cycles after the coordinate
//   bg_valid_o     bg_data_o valid
// ----------------------------------------------------------------------------
module bg_pattern_gen #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int CW          = 9,
  parameter int TILE_SHIFT  = 6,
  parameter int SCROLL_STEP = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [CW-1:0] h_count_i,
  input  logic [CW-1:0] v_count_i,
  input  logic          pix_valid_i,
  input  logic          frame_start_i,
  input  logic [1:0]    mode_i,
  input  logic [15:0]   color_a_i,
  input  logic [15:0]   color_b_i,
  output logic [15:0]   bg_data_o,
  output logic          bg_valid_o
);

  typedef enum logic [1:0] {
    MODE_CHECKER  = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } bgMode_e;

  localparam int            BAR_W = H_ACTIVE / 8;
  localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_LIM = CW'(V_ACTIVE);

  // Frame-latched mode. The frame_start pixel already uses the new request.
  bgMode_e modeActive_q;
  bgMode_e modeEff;

  assign modeEff = frame_start_i ? bgMode_e'(mode_i) : modeActive_q;

  // Scroll offset for the checker's x coordinate.
  logic [CW-1:0] offsetEff;

`ifdef BG_SCROLL_EN
  logic [CW-1:0] offset_q;

  // The frame_start pixel already sees the advanced offset.
  assign offsetEff = frame_start_i ? (offset_q + CW'(SCROLL_STEP)) : offset_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= '0;
    end else if (frame_start_i) begin
      offset_q <= offsetEff;
    end
  end
`else
  assign offsetEff = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      modeActive_q <= MODE_CHECKER;
    end else if (frame_start_i) begin
      modeActive_q <= bgMode_e'(mode_i);
    end
  end

  // Stage 1 next-state values.
  logic          inArea_d;
  logic [2:0]    bar_d;
  logic          sel_d;
  logic [3:0]    grad_d;
  logic [CW-1:0] hx;

  // The bar index uses a comparator chain against multiples of BAR_W.
  // Later thresholds override earlier ones, so x >= 7*BAR_W gives bar 7.
  always_comb begin
    inArea_d = (h_count_i < H_LIM) && (v_count_i < V_LIM);
    hx       = h_count_i + offsetEff;
    sel_d    = hx[TILE_SHIFT] ^ v_count_i[TILE_SHIFT];
    grad_d   = h_count_i[CW-1 -: 4];
    bar_d    = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_count_i >= CW'(k * BAR_W)) begin
        bar_d = 3'(k);
      end
    end
  end

  logic          inArea_q;
  logic [2:0]    bar_q;
  logic          sel_q;
  logic [3:0]    grad_q;
  bgMode_e       mode1_q;
  logic [15:0]   colA_q;
  logic [15:0]   colB_q;
  logic          valid1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inArea_q <= 1'b0;
      bar_q    <= 3'd0;
      sel_q    <= 1'b0;
      grad_q   <= 4'd0;
      mode1_q  <= MODE_CHECKER;
      colA_q   <= 16'h0000;
      colB_q   <= 16'h0000;
      valid1_q <= 1'b0;
    end else begin
      inArea_q <= inArea_d;
      bar_q    <= bar_d;
      sel_q    <= sel_d;
      grad_q   <= grad_d;
      mode1_q  <= modeEff;
      colA_q   <= color_a_i;
      colB_q   <= color_b_i;
      valid1_q <= pix_valid_i;
    end
  end

  // Stage 2 pixel selection. Anything outside the active area is black,
  // whatever the pattern.
  logic [15:0] pixel_d;

  always_comb begin
    pixel_d = 16'h0000;
    unique case (mode1_q)
      MODE_CHECKER:  pixel_d = sel_q ? colA_q : colB_q;
      MODE_BARS: begin
        unique case (bar_q)
          3'd0: pixel_d = 16'h0FFF;
          3'd1: pixel_d = 16'h0FF0;
          3'd2: pixel_d = 16'h00FF;
          3'd3: pixel_d = 16'h00F0;
          3'd4: pixel_d = 16'h0F0F;
          3'd5: pixel_d = 16'h0F00;
          3'd6: pixel_d = 16'h000F;
          3'd7: pixel_d = 16'h0000;
          default: pixel_d = 16'h0000;
        endcase
      end
      MODE_GRADIENT: pixel_d = {4'h0, grad_q, grad_q, grad_q};
      MODE_SOLID:    pixel_d = colA_q;
      default:       pixel_d = 16'h0000;
    endcase
    if (!inArea_q) begin
      pixel_d = 16'h0000;
    end
  end

  // bg_data holds its last value across invalid cycles.
  logic [15:0] bgData_q;
  logic        bgValid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bgData_q  <= 16'h0000;
      bgValid_q <= 1'b0;
    end else begin
      bgValid_q <= valid1_q;
      if (valid1_q) begin
        bgData_q <= pixel_d;
      end
    end
  end

  assign bg_data_o  = bgData_q;
  assign bg_valid_o = bgValid_q;

endmodule
